// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  localparam int          DEFAULT_ADDR_W = 14;
  localparam logic [31:0] PC_STEP        = 32'd4;

  // ROM size in bytes for a given word-address width; 33 bits so the limit itself is representable.
  function automatic logic [32:0] rom_bytes(input int addr_w);
    return 33'd4 << addr_w;
  endfunction

  localparam logic [32:0] ROM_BYTES = rom_bytes(DEFAULT_ADDR_W);

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter: synchronous reset to RESET_PC, enable, and increment/redirect load mux.
module pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] load_pc,
  output logic [31:0] pc
);

  logic [31:0] pc_value_reg;
  logic [31:0] pc_next;

  always_comb begin
    pc_next = load ? load_pc : pc_value_reg + PC_STEP;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_value_reg <= RESET_PC;
    end else if (en) begin
      pc_value_reg <= pc_next;
    end
  end

  assign pc = pc_value_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, combinational ROM address, one-entry valid/ready output stage, sticky fault.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 14
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              fault,
  output logic [31:0]       fault_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall
`endif
);

  localparam logic [32:0] ROM_LIMIT = rom_bytes(ADDR_W);
  localparam logic [31:0] LAST_PC   = ROM_LIMIT[31:0] - PC_STEP;

  fetch_state_t state_reg, state_next;
  logic         out_valid_reg, out_valid_next;
  logic [31:0]  out_instr_reg, out_instr_next;
  logic [31:0]  out_pc_reg, out_pc_next;
  logic         fault_reg, fault_next;
  logic [31:0]  fault_pc_reg, fault_pc_next;

  logic [31:0]  pc;
  logic         pc_en;
  logic         pc_load;
  logic         transfer;
  logic         fetch;
  logic         redirect_illegal;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .reset   (reset),
    .en      (pc_en),
    .load    (pc_load),
    .load_pc (redirect_pc),
    .pc      (pc)
  );

  assign rom_addr = pc[ADDR_W+1:2];

  assign transfer         = out_valid_reg && out_ready;
  assign fetch            = !out_valid_reg || out_ready;
  assign redirect_illegal = (redirect_pc[1:0] != 2'b00) || ({1'b0, redirect_pc} >= ROM_LIMIT);

  always_comb begin
    state_next     = state_reg;
    out_valid_next = out_valid_reg;
    out_instr_next = out_instr_reg;
    out_pc_next    = out_pc_reg;
    fault_next     = fault_reg;
    fault_pc_next  = fault_pc_reg;
    pc_en          = 1'b0;
    pc_load        = 1'b0;

    case (state_reg)
      RUN: begin
        // Redirect wins over fetch and flushes whatever has not been accepted yet.
        if (redirect) begin
          out_valid_next = 1'b0;
          if (redirect_illegal) begin
            state_next    = FAULT;
            fault_next    = 1'b1;
            fault_pc_next = redirect_pc;
          end else begin
            pc_en   = 1'b1;
            pc_load = 1'b1;
          end
        end else if (fetch) begin
          out_instr_next = rom_instr;
          out_pc_next    = pc;
          out_valid_next = 1'b1;
          pc_en          = 1'b1;
          // Last word of the ROM: deliver it, then stop fetching.
          if (pc == LAST_PC) begin
            state_next    = FAULT;
            fault_next    = 1'b1;
            fault_pc_next = ROM_LIMIT[31:0];
          end
        end
      end
      FAULT: begin
        if (transfer) begin
          out_valid_next = 1'b0;
        end
      end
      default: begin
        state_next = FAULT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= RUN;
      out_valid_reg <= 1'b0;
      out_instr_reg <= 32'd0;
      out_pc_reg    <= 32'd0;
      fault_reg     <= 1'b0;
      fault_pc_reg  <= 32'd0;
    end else begin
      state_reg     <= state_next;
      out_valid_reg <= out_valid_next;
      out_instr_reg <= out_instr_next;
      out_pc_reg    <= out_pc_next;
      fault_reg     <= fault_next;
      fault_pc_reg  <= fault_pc_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_instr = out_instr_reg;
  assign out_pc    = out_pc_reg;
  assign fault     = fault_reg;
  assign fault_pc  = fault_pc_reg;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_reg;
  logic [31:0] perf_stall_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_reg <= 32'd0;
      perf_stall_reg   <= 32'd0;
    end else begin
      if (transfer) begin
        perf_fetched_reg <= perf_fetched_reg + 32'd1;
      end
      if (out_valid_reg && !out_ready) begin
        perf_stall_reg <= perf_stall_reg + 32'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_reg;
  assign perf_stall   = perf_stall_reg;
`else
  // No performance counters in this build.
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage; sits directly upstream of the instruction ROM (romcode) and feeds fetched words to decode.
- Holds the PC and drives the 14-bit word address into the combinational ROM.
- Registers the returned instruction and its PC into a one-entry output stage with a valid/ready handshake.
- Accepts branch/jump redirects and enters a sticky fault state on an illegal PC.

Parameters:
- RESET_PC, 32'h0000_0000: byte address of the first fetch after reset; must be word aligned and below ROM_BYTES.
- ADDR_W, 14: ROM word-address width. ROM_BYTES = 4 << ADDR_W, which is 64 KB by default.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- rom_addr  out  ADDR_W  word address to ROM, equal to pc[ADDR_W+1:2]; purely combinational from pc
- rom_instr  in  32  ROM read data; combinational in rom_addr
- out_valid  out  1  out_instr/out_pc hold a valid fetched instruction
- out_ready  in  1  downstream accepts the output this cycle
- out_instr  out  32  fetched instruction
- out_pc  out  32  byte address of out_instr
- redirect  in  1  load a new PC; discard any output not yet accepted
- redirect_pc  in  32  redirect target, byte address
- fault  out  1  sticky illegal-PC indication
- fault_pc  out  32  offending PC

Behaviour:
- Single clock domain. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - pc = RESET_PC
  - out_valid = 0, out_instr = 0, out_pc = 0
  - fault = 0, fault_pc = 0
  - state = RUN
- States: RUN, FAULT.
- Fetch condition (RUN): fetch = !out_valid || out_ready. On a fetch:
  - out_instr <= rom_instr
  - out_pc <= pc
  - out_valid <= 1
  - pc <= pc + 4 (32-bit add)
- Latency: the instruction at pc is presented on out_* one cycle after pc is driven. Back-to-back fetches give one instruction per cycle while out_ready stays high.
- Stall: out_valid && !out_ready. Hold pc and all out_* stable. Registered outputs must not change while stalled.
- Handshake: a transfer occurs when out_valid && out_ready at the clock edge. Downstream may not depend on out_ready being high before out_valid.
- Redirect (RUN) has priority over fetch. On the edge where redirect is high:
  - out_valid <= 0, flushing any pending output.
  - If an out_valid && out_ready transfer coincides, that transfer still counts as completed.
  - pc <= redirect_pc.
  - No fetch occurs that cycle. The first fetch from the target lands the following cycle, giving a 2-cycle redirect bubble.
- Illegal PC: redirect_pc[1:0] != 0, or redirect_pc >= ROM_BYTES.
  - On a redirect to an illegal PC: state <= FAULT, fault <= 1, fault_pc <= redirect_pc, out_valid <= 0.
- Sequential overflow: if a fetch occurs at pc == ROM_BYTES-4:
  - That instruction is delivered normally.
  - state <= FAULT, fault <= 1, fault_pc <= ROM_BYTES.
  - The pending output stays valid until accepted, then out_valid <= 0.
- FAULT state:
  - No fetches; pc frozen.
  - redirect ignored.
  - fault stays 1; only reset exits.
  - rom_addr keeps following pc.
- Reset mid-operation: reset has priority over everything. A pending output is discarded and the first fetch after release comes from RESET_PC.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_fetched[31:0], counting completed out_* transfers.
  - Adds perf_stall[31:0], counting cycles with out_valid && !out_ready.
  - Both counters clear on reset and wrap modulo 2^32.
- When undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg holds:
  - the state enum, fetch_state_t {RUN, FAULT};
  - the localparam ROM_BYTES function of ADDR_W;
  - the constant PC_STEP = 4.
- Sub-module pc_reg: 32-bit register with synchronous active-high reset to RESET_PC, enable, and load mux (increment vs redirect_pc).
- The output stage and FSM stay in fetch_unit.

Test Plan:
- Reset release, with ROM[0..3] = 1111ffff, 22220000, deadbeaf, 00000004 and out_ready = 1:
  - out_valid rises 1 cycle after reset drops.
  - out_pc sequence is 0, 4, 8, C and out_instr sequence is 1111ffff, 22220000, deadbeaf, 00000004, one per cycle.
- Stall: hold out_ready = 0 for 3 cycles while out_pc = 4.
  - out_instr stays 22220000, pc holds, and rom_addr stays 2 throughout.
  - Releasing out_ready resumes with out_pc = 8 on the next cycle.
- Redirect while out_valid = 1 and out_ready = 0: redirect_pc = 0x100.
  - out_valid = 0 the next cycle.
  - The cycle after, out_pc = 0x100 and out_instr = ROM[64].
- Misaligned redirect to 0x102:
  - fault = 1, fault_pc = 0x102, and out_valid stays 0.
  - A later redirect to 0x0 is ignored; reset clears fault.
- Sequential overflow: redirect to 0xFFFC.
  - The instruction at 0xFFFC is delivered.
  - Then fault = 1, fault_pc = 0x10000, and no further out_valid.
- Simultaneous redirect with out_ready = 1 and out_valid = 1 at 0x8: redirect_pc = 0x20.
  - The 0x8 transfer counts, and the next valid out_pc is 0x20.
  - With FETCH_PERF_CNT_EN defined, perf_fetched increments by 1 for the 0x8 transfer.
